// File: rtl/pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pipe_pkg
// Brief    : Shared types and constants for the inter-stage pipeline registers.
// Revision : 1.0 - initial release
// ============================================================================
package pipe_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } stage_state_e;

    // Bundle widths for each stage boundary
    localparam int c_ifid_ctrl_w  = 1;
    localparam int c_ifid_data_w  = 64;
    localparam int c_idex_ctrl_w  = 8;
    localparam int c_idex_data_w  = 111;
    localparam int c_exmem_ctrl_w = 4;
    localparam int c_exmem_data_w = 69;
    localparam int c_memwb_ctrl_w = 2;
    localparam int c_memwb_data_w = 69;

    localparam int c_bit_reg_dst    = 0;
    localparam int c_bit_alu_op_lo  = 1;
    localparam int c_bit_alu_op_hi  = 2;
    localparam int c_bit_alu_src    = 3;
    localparam int c_bit_mem_read   = 4;
    localparam int c_bit_mem_write  = 5;
    localparam int c_bit_reg_write  = 6;
    localparam int c_bit_mem_to_reg = 7;

    function automatic logic is_bubble(input logic [7:0] ctrl);
        return (ctrl == 8'd0);
    endfunction

endpackage
`default_nettype wire

// File: rtl/sat_counter.sv
`default_nettype none
// ============================================================================
// Module   : sat_counter
// Brief    : Up-counter that sticks at all-ones instead of wrapping.
// Revision : 1.0 - initial release
// ============================================================================
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_inc,
    output logic [CNT_W-1:0] o_count
);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_count <= '0;
        end else if (i_inc && (r_count != '1)) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    assign o_count = r_count;

endmodule
`default_nettype wire

// File: rtl/pipe_stage_reg.sv
`default_nettype none
// ============================================================================
// Module   : pipe_stage_reg
// Brief    : Valid/ready stage register with optional skid entry, flush and stall counter.
// Revision : 1.0 - initial release
// ============================================================================
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int CTRL_W = 8,
    parameter int DATA_W = 111,
    parameter int SKID   = 1,
    parameter int CNT_W  = 16
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              valid_i,
    output logic              ready_o,
    input  logic [CTRL_W-1:0] ctrl_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic              flush_i,
    output logic              valid_o,
    input  logic              ready_i,
    output logic [CTRL_W-1:0] ctrl_o,
    output logic [DATA_W-1:0] data_o,
    output logic [CNT_W-1:0]  stall_cnt_o
);

    logic              w_accept;
    logic              w_consume;
    logic              r_valid;
    logic [CTRL_W-1:0] r_ctrl;
    logic [DATA_W-1:0] r_data;

    assign w_accept  = valid_i & ready_o;
    assign w_consume = r_valid & ready_i;

    generate
        if (SKID != 0) begin : g_skid
            stage_state_e      r_state;
            logic              r_ready;
            logic [CTRL_W-1:0] r_skid_ctrl;
            logic [DATA_W-1:0] r_skid_data;

            // ready_o comes straight from a flop so ready_i never reaches it
            always_ff @(posedge clk_i or negedge rst_n_i) begin
                if (!rst_n_i) begin
                    r_state     <= EMPTY;
                    r_valid     <= 1'b0;
                    r_ready     <= 1'b1;
                    r_ctrl      <= '0;
                    r_data      <= '0;
                    r_skid_ctrl <= '0;
                    r_skid_data <= '0;
                end else if (flush_i) begin
                    r_state <= EMPTY;
                    r_valid <= 1'b0;
                    r_ready <= 1'b1;
                end else begin
                    case (r_state)
                        EMPTY: begin
                            if (w_accept) begin
                                r_ctrl  <= ctrl_i;
                                r_data  <= data_i;
                                r_valid <= 1'b1;
                                r_state <= ONE;
                            end
                        end
                        ONE: begin
                            if (w_accept && w_consume) begin
                                r_ctrl <= ctrl_i;
                                r_data <= data_i;
                            end else if (w_accept) begin
                                r_skid_ctrl <= ctrl_i;
                                r_skid_data <= data_i;
                                r_state     <= FULL;
                                r_ready     <= 1'b0;
                            end else if (w_consume) begin
                                r_valid <= 1'b0;
                                r_state <= EMPTY;
                            end
                        end
                        FULL: begin
                            if (w_consume) begin
                                r_ctrl  <= r_skid_ctrl;
                                r_data  <= r_skid_data;
                                r_state <= ONE;
                                r_ready <= 1'b1;
                            end
                        end
                        default: begin
                            r_state <= EMPTY;
                            r_valid <= 1'b0;
                            r_ready <= 1'b1;
                        end
                    endcase
                end
            end

            assign ready_o = r_ready;
        end else begin : g_single
            always_ff @(posedge clk_i or negedge rst_n_i) begin
                if (!rst_n_i) begin
                    r_valid <= 1'b0;
                    r_ctrl  <= '0;
                    r_data  <= '0;
                end else if (flush_i) begin
                    r_valid <= 1'b0;
                end else if (w_accept) begin
                    r_valid <= 1'b1;
                    r_ctrl  <= ctrl_i;
                    r_data  <= data_i;
                end else if (w_consume) begin
                    r_valid <= 1'b0;
                end
            end

            assign ready_o = ready_i | ~r_valid;
        end
    endgenerate

    // A stale control word must never look like a live instruction downstream
    assign valid_o = r_valid;
    assign ctrl_o  = r_valid ? r_ctrl : '0;
    assign data_o  = r_data;

    sat_counter #(
        .CNT_W(CNT_W)
    ) u_stall_cnt (
        .i_clk  (clk_i),
        .i_rst_n(rst_n_i),
        .i_inc  (r_valid & ~ready_i),
        .o_count(stall_cnt_o)
    );

endmodule
`default_nettype wire

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised pipeline stage register for the five-stage CPU, the successor of the fixed-field inter-stage latches. It carries a control bundle and a data bundle between adjacent stages with a valid/ready handshake, an optional two-entry skid buffer that keeps upstream `ready` registered, synchronous flush (bubble insertion), and a saturating stall-cycle counter. One instance sits at each stage boundary (IF/ID, ID/EX, EX/MEM, MEM/WB).

## Interface
- `CTRL_W`, default 8: control bundle width (WB/M/EX bits); all-zero encodes a bubble.
- `DATA_W`, default 111: data bundle width (register addresses, operands, immediates).
- `SKID`, default 1: 1 = two-entry skid buffer with registered `ready_o`; 0 = single register with combinational `ready_o`.
- `CNT_W`, default 16: stall counter width.

Ports:
- `clk_i` in, 1: clock; all state updates on the rising edge.
- `rst_n_i` in, 1: reset; asynchronous, active-low.
- `valid_i` in, 1: upstream beat valid.
- `ready_o` out, 1: stage can accept a beat.
- `ctrl_i` in, CTRL_W: upstream control bundle.
- `data_i` in, DATA_W: upstream data bundle.
- `flush_i` in, 1: synchronous kill of all held and incoming beats.
- `valid_o` out, 1: output beat valid.
- `ready_i` in, 1: downstream accepts (deasserted by the hazard unit to stall).
- `ctrl_o` out, CTRL_W: output control; forced to 0 whenever `valid_o` = 0.
- `data_o` out, DATA_W: output data; holds its last value when invalid.
- `stall_cnt_o` out, CNT_W: saturating count of cycles with `valid_o & ~ready_i`.

## Operation
- Accept: `valid_i & ready_o`. Consume: `valid_o & ready_i`.
- SKID=1 states: EMPTY (no valid entry), ONE (output register valid), FULL (output and skid valid).
  - EMPTY: accept -> ONE.
  - ONE: accept & consume -> ONE (new beat into output register). Accept & ~consume -> FULL (beat into skid). Consume only -> EMPTY.
  - FULL: `ready_o` = 0. Consume -> ONE (skid moves into output register). Otherwise hold.
  - `ready_o` = (state != FULL), a registered decode.
- SKID=0: a single entry. `ready_o` = `ready_i | ~valid_o`. Accept loads the register; consume without accept clears `valid_o`.
- Flush: next state is EMPTY, and any beat accepted in the same cycle is discarded. Flush has priority over accept and consume. `data_o` is not cleared.
- Ordering: beats leave in acceptance order. No beat is duplicated or dropped except by flush.
- Counter: increments each cycle `valid_o & ~ready_i` is true, saturates at all-ones, and is cleared only by reset. Flush does not affect it.
- Reset (asynchronous, any time including mid-transfer): state EMPTY, `valid_o` 0, `ctrl_o` 0, `data_o` 0, skid contents 0, `ready_o` 1, `stall_cnt_o` 0.

## Timing
- Latency: a beat accepted at edge N appears on `valid_o`/`ctrl_o`/`data_o` after edge N. One-cycle latency in both modes.
- Throughput: 1 beat/cycle while `ready_i` = 1.
- SKID=1: `ready_o` depends only on flops; there is no combinational path from `ready_i` to `ready_o`. Upstream may present one extra beat after `ready_i` falls, and it lands in the skid entry.
- SKID=0: combinational path `ready_i` -> `ready_o`.
- `flush_i` and `ready_i` are sampled at the edge. A flush asserted in cycle N gives `valid_o` = 0 after edge N.
- Simultaneous flush and reset: reset wins (asynchronous).
- Counter saturation: at all-ones it stays at all-ones and does not wrap.

## Structure
- Package `pipe_pkg`:
  - state enum {EMPTY, ONE, FULL};
  - per-boundary `CTRL_W`/`DATA_W` constants;
  - control bit-position constants (RegDst, ALUOp, ALUSrc, MemRead/HD, MemWrite, RegWrite, MemtoReg).
- One sub-module, `sat_counter`, with parameter `CNT_W`, an increment enable and an asynchronous active-low reset. It is used for `stall_cnt_o`.
- Field packing and unpacking of `ctrl`/`data` is done by the instantiating stage, not inside this block.

## Test plan
- Reset then stream: after reset, drive 8 beats `data_i` = 1..8 with `ready_i` = 1. Required: `data_o` = 1..8 on consecutive cycles with one-cycle latency, `ready_o` held 1, `stall_cnt_o` = 0.
- Backpressure (SKID=1): deassert `ready_i` while streaming. Required:
  - exactly one extra beat accepted, then `ready_o` = 0;
  - after 3 stall cycles, `stall_cnt_o` = 3;
  - on re-assert, beats drain in order with no loss.
- Flush in FULL with a simultaneous `valid_i` (`data_i` = 0xAA). Required:
  - next cycle `valid_o` = 0, `ctrl_o` = 0, `ready_o` = 1;
  - 0xAA never appears on `valid_o`.
- SKID=0 stall: with `ready_i` = 0 and `valid_o` = 1, `ready_o` = 0 in the same cycle. `data_o` holds its value until `ready_i` = 1.
- Async reset mid-stream: assert `rst_n_i` between edges while in FULL. Required: all outputs go to reset values immediately, without waiting for a clock edge.
- Saturation: with `CNT_W` = 4, stall for 20 cycles. Required: `stall_cnt_o` = 15 and held there.
